// File: rtl/axi4_plic_regbus_bridge_if.sv
// AXI4 slave-side bundle for the PLIC regbus bridge.
// Master modport drives requests; slave modport answers.
interface axi4_plic_regbus_bridge_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 8
);
  logic [ID_BITS-1:0]     arid;
  logic [ADDR_BITS-1:0]   araddr;
  logic [LEN_BITS-1:0]    arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [ID_BITS-1:0]     rid;
  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;
  logic [ID_BITS-1:0]     awid;
  logic [ADDR_BITS-1:0]   awaddr;
  logic [LEN_BITS-1:0]    awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [ID_BITS-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi4_plic_regbus_bridge.sv
// AXI4 slave to PLIC regbus bridge.
// Independent read and write engines, one regbus access per beat.
module axi4_plic_regbus_bridge #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 8,
  parameter int WIN_BITS  = 26
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  axi4_plic_regbus_bridge_if.slave axi,
  output logic                   reg_ren,
  output logic [ADDR_BITS-1:0]   reg_raddr,
  input  logic [DATA_BITS-1:0]   reg_rdata,
  output logic [DATA_BITS/8-1:0] reg_wen,
  output logic [ADDR_BITS-1:0]   reg_waddr,
  output logic [DATA_BITS-1:0]   reg_wdata
);
  localparam int SZMAX = $clog2(DATA_BITS/8);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  function automatic logic [ADDR_BITS-1:0] next_addr(
    input logic [ADDR_BITS-1:0] a,
    input logic [2:0]           sz,
    input logic [LEN_BITS-1:0]  len,
    input logic [1:0]           bt
  );
    logic [ADDR_BITS-1:0] incr;
    logic [ADDR_BITS-1:0] algn;
    logic [ADDR_BITS-1:0] span;
    logic [ADDR_BITS-1:0] nxt;
    incr = ADDR_BITS'(1) << sz;
    algn = a & ~(incr - ADDR_BITS'(1));
    span = (ADDR_BITS'(len) + ADDR_BITS'(1)) << sz;
    unique case (1'b1)
      (bt == 2'b00): nxt = a;
      (bt == 2'b10): nxt = (a & ~(span - ADDR_BITS'(1)))
                         | ((algn + incr) & (span - ADDR_BITS'(1)));
      default:       nxt = algn + incr;
    endcase
    return nxt;
  endfunction

  function automatic logic burst_err(
    input logic [2:0]          sz,
    input logic [1:0]          bt,
    input logic [LEN_BITS-1:0] len
  );
    logic wrap_ok;
    wrap_ok = (len == LEN_BITS'(1)) || (len == LEN_BITS'(3))
           || (len == LEN_BITS'(7)) || (len == LEN_BITS'(15));
    return (sz > 3'(SZMAX)) || (bt == 2'b11)
        || ((bt == 2'b10) && !wrap_ok);
  endfunction

  function automatic logic oob(input logic [ADDR_BITS-1:0] a);
    return a[ADDR_BITS-1:WIN_BITS] != '0;
  endfunction

  rstate_e               rs_q, rs_d;
  logic [ID_BITS-1:0]    rid_q, rid_d;
  logic [ADDR_BITS-1:0]  raddr_q, raddr_d;
  logic [LEN_BITS-1:0]   rlen_q, rlen_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [LEN_BITS-1:0]   rcnt_q, rcnt_d;
  logic                  rberr_q, rberr_d;
  logic                  rhold_q, rhold_d;
  logic [DATA_BITS-1:0]  rdata_q, rdata_d;

  wstate_e               ws_q, ws_d;
  logic [ID_BITS-1:0]    wid_q, wid_d;
  logic [ADDR_BITS-1:0]  waddr_q, waddr_d;
  logic [LEN_BITS-1:0]   wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [LEN_BITS-1:0]   wcnt_q, wcnt_d;
  logic                  wberr_q, wberr_d;
  logic                  wover_q, wover_d;
  logic                  werr_q, werr_d;

  logic                  rill;
  logic                  will;
  logic [DATA_BITS-1:0]  rfresh;

  assign rill   = rberr_q || oob(raddr_q);
  assign will   = wberr_q || wover_q || oob(waddr_q);
  assign rfresh = rill ? '0 : reg_rdata;

  // State and burst context registers for both engines
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rs_q     <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rberr_q  <= 1'b0;
      rhold_q  <= 1'b0;
      rdata_q  <= '0;
      ws_q     <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      wberr_q  <= 1'b0;
      wover_q  <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      rs_q     <= rs_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rberr_q  <= rberr_d;
      rhold_q  <= rhold_d;
      rdata_q  <= rdata_d;
      ws_q     <= ws_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      wberr_q  <= wberr_d;
      wover_q  <= wover_d;
      werr_q   <= werr_d;
    end
  end

  // Read engine: fetch one word, hold it until the beat is taken
  always_comb begin
    rs_d     = rs_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rberr_d  = rberr_q;
    rhold_d  = rhold_q;
    rdata_d  = rdata_q;
    unique case (rs_q)
      R_IDLE: begin
        if (axi.arvalid) begin
          rid_d    = axi.arid;
          raddr_d  = axi.araddr;
          rlen_d   = axi.arlen;
          rsize_d  = axi.arsize;
          rburst_d = axi.arburst;
          rcnt_d   = '0;
          rberr_d  = burst_err(axi.arsize, axi.arburst, axi.arlen);
          rs_d     = R_FETCH;
        end
      end
      R_FETCH: begin
        rhold_d = 1'b0;
        rs_d    = R_DATA;
      end
      R_DATA: begin
        if (!rhold_q) begin
          rdata_d = rfresh;
          rhold_d = 1'b1;
        end
        if (axi.rready) begin
          if (rcnt_q == rlen_q) begin
            rs_d = R_IDLE;
          end else begin
            raddr_d = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
            rcnt_d  = rcnt_q + LEN_BITS'(1);
            rs_d    = R_FETCH;
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // Write engine: one regbus write per W beat, sticky error to B
  always_comb begin
    ws_d     = ws_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    wberr_d  = wberr_q;
    wover_d  = wover_q;
    werr_d   = werr_q;
    unique case (ws_q)
      W_IDLE: begin
        if (axi.awvalid) begin
          wid_d    = axi.awid;
          waddr_d  = axi.awaddr;
          wlen_d   = axi.awlen;
          wsize_d  = axi.awsize;
          wburst_d = axi.awburst;
          wcnt_d   = '0;
          wberr_d  = burst_err(axi.awsize, axi.awburst, axi.awlen);
          wover_d  = 1'b0;
          werr_d   = 1'b0;
          ws_d     = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.wvalid) begin
          if (will) werr_d = 1'b1;
          if (axi.wlast) begin
            if (!wover_q && (wcnt_q != wlen_q)) werr_d = 1'b1;
            ws_d = W_RESP;
          end else if (wcnt_q == wlen_q) begin
            wover_d = 1'b1;
            werr_d  = 1'b1;
          end else begin
            wcnt_d  = wcnt_q + LEN_BITS'(1);
            waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
          end
        end
      end
      W_RESP: begin
        if (axi.bready) ws_d = W_IDLE;
      end
      default: ws_d = W_IDLE;
    endcase
  end

  // Bus outputs decoded from engine state
  always_comb begin
    axi.arready = (rs_q == R_IDLE);
    axi.rvalid  = (rs_q == R_DATA);
    axi.rid     = rid_q;
    axi.rdata   = (axi.rvalid && !rhold_q) ? rfresh : rdata_q;
    axi.rresp   = (axi.rvalid && rill) ? 2'b10 : 2'b00;
    axi.rlast   = axi.rvalid && (rcnt_q == rlen_q);
    reg_ren     = (rs_q == R_FETCH) && !rill;
    reg_raddr   = raddr_q;
    axi.awready = (ws_q == W_IDLE);
    axi.wready  = (ws_q == W_DATA);
    axi.bvalid  = (ws_q == W_RESP);
    axi.bid     = wid_q;
    axi.bresp   = (axi.bvalid && werr_q) ? 2'b10 : 2'b00;
    reg_wen     = (axi.wready && axi.wvalid && !will) ? axi.wstrb : '0;
    reg_waddr   = waddr_q;
    reg_wdata   = axi.wdata;
  end
endmodule

// File: tb/tb_axi4_plic_regbus_bridge.sv
// Directed bench for the AXI4 to PLIC regbus bridge.
// Vector table plus reset and concurrency sequences.
module tb_axi4_plic_regbus_bridge;
  localparam int AB = 32;
  localparam int DB = 32;
  localparam int IB = 4;
  localparam int LB = 8;

  typedef struct {
    bit               wr;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    int               wbeats;
    logic [15:0]      emask;
    int               nacc;
    logic [3:0][31:0] ea;
  } vec_t;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          reg_ren;
  logic [AB-1:0] reg_raddr;
  logic [DB-1:0] reg_rdata = '0;
  logic [3:0]    reg_wen;
  logic [AB-1:0] reg_waddr;
  logic [DB-1:0] reg_wdata;

  axi4_plic_regbus_bridge_if #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .ID_BITS(IB), .LEN_BITS(LB)
  ) axi ();

  axi4_plic_regbus_bridge #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .ID_BITS(IB), .LEN_BITS(LB), .WIN_BITS(26)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .axi(axi),
    .reg_ren(reg_ren),
    .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata),
    .reg_wen(reg_wen),
    .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] ren_log[$];
  logic [31:0] wen_addr[$];
  logic [31:0] wen_data[$];
  logic [3:0]  wen_strb[$];
  int rv_cnt = 0;
  int bv_cnt = 0;
  vec_t vt[13];

  function automatic logic [31:0] rmodel(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Register-file stand-in: data valid the cycle after reg_ren
  always @(posedge PCLK)
    if (reg_ren) reg_rdata <= rmodel(reg_raddr);

  // Regbus and response monitor, sampled mid-cycle
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (reg_ren) ren_log.push_back(reg_raddr);
      if (reg_wen != 4'h0) begin
        wen_addr.push_back(reg_waddr);
        wen_data.push_back(reg_wdata);
        wen_strb.push_back(reg_wen);
      end
      if (axi.rvalid) rv_cnt++;
      if (axi.bvalid) bv_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  function automatic vec_t mkv(
    input bit wr, input logic [31:0] addr, input logic [7:0] len,
    input logic [2:0] size, input logic [1:0] burst,
    input logic [3:0] id, input int wbeats, input logic [15:0] emask,
    input int nacc, input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size;
    v.burst = burst; v.id = id; v.wbeats = wbeats;
    v.emask = emask; v.nacc = nacc;
    v.ea = {a3, a2, a1, a0};
    return v;
  endfunction

  task automatic do_read(input vec_t v, input bit tog);
    bit ok;
    int k;
    axi.arid = v.id; axi.araddr = v.addr; axi.arlen = v.len;
    axi.arsize = v.size; axi.arburst = v.burst; axi.arvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (axi.arready) begin ok = 1; step(); break; end
      step();
    end
    axi.arvalid = 1'b0;
    chk("ar handshake", 64'(ok), 64'd1);
    k = 0;
    for (int i = 0; i <= int'(v.len); i++) begin
      ok = 0;
      for (int n = 0; n < 200; n++) begin
        axi.rready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axi.rvalid && axi.rready) begin
          ok = 1;
          chk("rresp", 64'(axi.rresp), v.emask[i] ? 64'd2 : 64'd0);
          chk("rid", 64'(axi.rid), 64'(v.id));
          chk("rlast", 64'(axi.rlast), 64'(i == int'(v.len)));
          if (v.emask[i]) begin
            chk("rdata err", 64'(axi.rdata), 64'd0);
          end else begin
            chk("rdata", 64'(axi.rdata), 64'(rmodel(v.ea[k])));
            k++;
          end
          step();
          break;
        end
        step();
      end
      axi.rready = 1'b0;
      chk("r beat wait", 64'(ok), 64'd1);
    end
  endtask

  task automatic do_write(input vec_t v);
    bit ok;
    axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len;
    axi.awsize = v.size; axi.awburst = v.burst; axi.awvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (axi.awready) begin ok = 1; step(); break; end
      step();
    end
    axi.awvalid = 1'b0;
    chk("aw handshake", 64'(ok), 64'd1);
    for (int i = 0; i < v.wbeats; i++) begin
      axi.wdata = 32'h1000 + 32'(i);
      axi.wstrb = (i == 0) ? 4'h3 : 4'hF;
      axi.wlast = (i == v.wbeats - 1);
      axi.wvalid = 1'b1;
      ok = 0;
      for (int n = 0; n < 100; n++) begin
        if (axi.wready) begin ok = 1; step(); break; end
        step();
      end
      axi.wvalid = 1'b0;
      chk("w beat wait", 64'(ok), 64'd1);
    end
    axi.wlast = 1'b0;
    axi.bready = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (axi.bvalid) begin
        ok = 1;
        chk("bid", 64'(axi.bid), 64'(v.id));
        chk("bresp", 64'(axi.bresp), v.emask[0] ? 64'd2 : 64'd0);
        step();
        break;
      end
      step();
    end
    axi.bready = 1'b0;
    chk("b wait", 64'(ok), 64'd1);
  endtask

  task automatic check_log(input vec_t v, input int rb, input int wb);
    int cnt;
    if (!v.wr) begin
      cnt = ren_log.size() - rb;
      chk("reg_ren count", 64'(cnt), 64'(v.nacc));
      for (int k = 0; k < v.nacc && k < cnt; k++)
        chk("reg_raddr", 64'(ren_log[rb+k]), 64'(v.ea[k]));
    end else begin
      cnt = wen_addr.size() - wb;
      chk("reg_wen count", 64'(cnt), 64'(v.nacc));
      for (int k = 0; k < v.nacc && k < cnt; k++) begin
        chk("reg_waddr", 64'(wen_addr[wb+k]), 64'(v.ea[k]));
        chk("reg_wen", 64'(wen_strb[wb+k]), (k == 0) ? 64'h3 : 64'hF);
        chk("reg_wdata", 64'(wen_data[wb+k]), 64'h1000 + 64'(k));
      end
    end
  endtask

  initial begin
    int rb;
    int wb;
    int rv0;
    int bv0;
    vec_t vr;
    vec_t vw;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
    axi.awburst = '0; axi.awvalid = 1'b0; axi.wdata = '0;
    axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;

    vt[0]  = mkv(0, 32'h4, 3, 2, 2'b01, 4'h5, 0, 16'h0, 4,
                 32'h4, 32'h8, 32'hC, 32'h10);
    vt[1]  = mkv(0, 32'h18, 3, 2, 2'b10, 4'h1, 0, 16'h0, 4,
                 32'h18, 32'h1C, 32'h10, 32'h14);
    vt[2]  = mkv(1, 32'h200000, 1, 2, 2'b01, 4'h9, 2, 16'h0, 2,
                 32'h200000, 32'h200004, 0, 0);
    vt[3]  = mkv(1, 32'h100, 3, 2, 2'b01, 4'h2, 2, 16'h1, 2,
                 32'h100, 32'h104, 0, 0);
    vt[4]  = mkv(0, 32'h0400_0000, 0, 2, 2'b01, 4'h3, 0, 16'h1, 0,
                 0, 0, 0, 0);
    vt[5]  = mkv(0, 32'h8, 0, 3, 2'b01, 4'h4, 0, 16'h1, 0,
                 0, 0, 0, 0);
    vt[6]  = mkv(0, 32'h20, 2, 2, 2'b10, 4'h6, 0, 16'h7, 0,
                 0, 0, 0, 0);
    vt[7]  = mkv(0, 32'h40, 2, 2, 2'b00, 4'h7, 0, 16'h0, 3,
                 32'h40, 32'h40, 32'h40, 0);
    vt[8]  = mkv(1, 32'h80, 1, 2, 2'b01, 4'h8, 3, 16'h1, 2,
                 32'h80, 32'h84, 0, 0);
    vt[9]  = mkv(0, 32'h03FF_FFFC, 1, 2, 2'b01, 4'hA, 0, 16'h2, 1,
                 32'h03FF_FFFC, 0, 0, 0);
    vt[10] = mkv(0, 32'h8, 1, 2, 2'b11, 4'hB, 0, 16'h3, 0,
                 0, 0, 0, 0);
    vt[11] = mkv(1, 32'h3C, 1, 2, 2'b10, 4'hC, 2, 16'h0, 2,
                 32'h3C, 32'h38, 0, 0);
    vt[12] = mkv(0, 32'h5, 1, 0, 2'b01, 4'hD, 0, 16'h0, 2,
                 32'h5, 32'h6, 0, 0);

    #12;
    chk("rst arready", 64'(axi.arready), 64'd1);
    chk("rst awready", 64'(axi.awready), 64'd1);
    chk("rst wready", 64'(axi.wready), 64'd0);
    chk("rst rvalid", 64'(axi.rvalid), 64'd0);
    chk("rst bvalid", 64'(axi.bvalid), 64'd0);
    chk("rst rlast", 64'(axi.rlast), 64'd0);
    chk("rst reg_ren", 64'(reg_ren), 64'd0);
    chk("rst reg_wen", 64'(reg_wen), 64'd0);
    chk("rst rdata", 64'(axi.rdata), 64'd0);
    chk("rst rresp", 64'(axi.rresp), 64'd0);
    chk("rst bresp", 64'(axi.bresp), 64'd0);
    chk("rst rid", 64'(axi.rid), 64'd0);
    chk("rst bid", 64'(axi.bid), 64'd0);
    PRESETn = 1'b1;
    step();
    step();

    for (int i = 0; i < 13; i++) begin
      rb = ren_log.size();
      wb = wen_addr.size();
      if (vt[i].wr) do_write(vt[i]);
      else do_read(vt[i], 1'b0);
      step();
      check_log(vt[i], rb, wb);
    end

    vr = mkv(0, 32'h4, 3, 2, 2'b01, 4'h3, 0, 16'h0, 4,
             32'h4, 32'h8, 32'hC, 32'h10);
    vw = mkv(1, 32'h300, 3, 2, 2'b01, 4'h7, 4, 16'h0, 4,
             32'h300, 32'h304, 32'h308, 32'h30C);
    rb = ren_log.size();
    wb = wen_addr.size();
    fork
      do_read(vr, 1'b1);
      do_write(vw);
    join
    step();
    check_log(vr, rb, wb);
    check_log(vw, rb, wb);

    axi.arid = 4'h6; axi.araddr = 32'h4; axi.arlen = 3;
    axi.arsize = 2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    axi.awid = 4'h2; axi.awaddr = 32'h500; axi.awlen = 3;
    axi.awsize = 2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
    step();
    axi.arvalid = 1'b0;
    axi.awvalid = 1'b0;
    axi.wdata = 32'hDEAD; axi.wstrb = 4'hF;
    axi.wlast = 1'b0; axi.wvalid = 1'b1;
    step();
    axi.wvalid = 1'b0;
    step();
    chk("midburst rvalid", 64'(axi.rvalid), 64'd1);
    chk("midburst wready", 64'(axi.wready), 64'd1);
    PRESETn = 1'b0;
    #1;
    chk("abort rvalid", 64'(axi.rvalid), 64'd0);
    chk("abort arready", 64'(axi.arready), 64'd1);
    chk("abort awready", 64'(axi.awready), 64'd1);
    chk("abort wready", 64'(axi.wready), 64'd0);
    chk("abort reg_ren", 64'(reg_ren), 64'd0);
    chk("abort rid", 64'(axi.rid), 64'd0);
    step();
    step();
    PRESETn = 1'b1;
    axi.rready = 1'b1;
    axi.bready = 1'b1;
    rv0 = rv_cnt;
    bv0 = bv_cnt;
    for (int n = 0; n < 10; n++) step();
    chk("abort no R", 64'(rv_cnt - rv0), 64'd0);
    chk("abort no B", 64'(bv_cnt - bv0), 64'd0);
    axi.rready = 1'b0;
    axi.bready = 1'b0;

    rb = ren_log.size();
    wb = wen_addr.size();
    do_read(vt[1], 1'b0);
    step();
    check_log(vt[1], rb, wb);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
